// File: rtl/rs_pkg.sv
// Shared definitions for the debounced RS pulse generator: channel states,
// default debounce length and channel indices.
package rs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } chan_state_t;

  localparam int DB_CYCLES_DEF = 16;

  localparam int CH_SET = 0;
  localparam int CH_RST = 1;

endpackage

// File: rtl/db_chan.sv
// One debounce channel: 2-flop synchronizer, press/release FSM and counter.
// fire is combinational and marks the cycle in which a press is accepted.
module db_chan
  import rs_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 5
) (
  input  logic c,
  input  logic r_n,
  input  logic raw,
  output logic fire,
  output logic not_idle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_reg;
  logic             syn_reg;
  chan_state_t      state_reg;
  chan_state_t      state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge c) begin
    if (!r_n) begin
      sync_reg  <= 1'b0;
      syn_reg   <= 1'b0;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= raw;
      syn_reg   <= sync_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Every transition clears the counter, so it can never reach past CNT_LAST.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fire       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (syn_reg) begin
          state_next = ST_DB_PRESS;
          cnt_next   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!syn_reg) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_HELD;
          cnt_next   = '0;
          fire       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HELD: begin
        if (!syn_reg) begin
          state_next = ST_DB_REL;
          cnt_next   = '0;
        end
      end
      ST_DB_REL: begin
        if (syn_reg) begin
          state_next = ST_HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign not_idle = (state_reg != ST_IDLE);

endmodule

// File: rtl/rs_pulse_gen.sv
// Debounces the set and reset buttons and turns each accepted press into a
// single-cycle registered strobe; reset wins when both fire together.
module rs_pulse_gen
  import rs_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 5
) (
  input  logic c,
  input  logic r_n,
  input  logic bs,
  input  logic br,
  output logic s,
  output logic r,
  output logic busy
);

  logic [1:0] raw;
  logic [1:0] fire;
  logic [1:0] not_idle;
  logic       s_reg;
  logic       r_reg;

  assign raw[CH_SET] = bs;
  assign raw[CH_RST] = br;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    db_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .c        (c),
      .r_n      (r_n),
      .raw      (raw[gi]),
      .fire     (fire[gi]),
      .not_idle (not_idle[gi])
    );
  end

  // A set fire that loses to reset is dropped, not deferred.
  always_ff @(posedge c) begin
    if (!r_n) begin
      s_reg <= 1'b0;
      r_reg <= 1'b0;
    end else begin
      s_reg <= fire[CH_SET] & ~fire[CH_RST];
      r_reg <= fire[CH_RST];
    end
  end

  assign s    = s_reg;
  assign r    = r_reg;
  assign busy = |not_idle;

endmodule

// File: tb/tb_rs_pulse_gen.sv
// Directed bench for rs_pulse_gen with DB_CYCLES=4: press latency, glitch
// rejection, bounce, simultaneous fire, reset mid-press and long hold.
module tb_rs_pulse_gen;

  logic c = 1'b0;
  logic r_n;
  logic bs;
  logic br;
  logic s;
  logic r;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int s_cnt    = 0;
  int r_cnt    = 0;
  int both_cnt = 0;
  int s_base;
  int r_base;

  always #5 c = ~c;

  rs_pulse_gen #(
    .DB_CYCLES (4),
    .CNT_W     (5)
  ) dut (
    .c    (c),
    .r_n  (r_n),
    .bs   (bs),
    .br   (br),
    .s    (s),
    .r    (r),
    .busy (busy)
  );

  always @(negedge c) begin
    if (s === 1'b1) s_cnt++;
    if (r === 1'b1) r_cnt++;
    if (s === 1'b1 && r === 1'b1) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic mark();
    s_base = s_cnt;
    r_base = r_cnt;
  endtask

  initial begin
    r_n = 1'b0;
    bs  = 1'b0;
    br  = 1'b0;
    step(3);
    check_val("rst_s", 32'(s), 0);
    check_val("rst_r", 32'(r), 0);
    check_val("rst_busy", 32'(busy), 0);
    $display("txn reset s=%0b r=%0b busy=%0b", s, r, busy);
    r_n = 1'b1;
    step(2);

    // Clean press held for 20 sampled edges
    mark();
    bs = 1'b1;
    step(2);
    check_val("press_busy_e1", 32'(busy), 0);
    step(1);
    check_val("press_busy_e2", 32'(busy), 1);
    step(3);
    check_val("press_s_e5", 32'(s), 0);
    step(1);
    check_val("press_s_e6", 32'(s), 1);
    check_val("press_r_e6", 32'(r), 0);
    step(1);
    check_val("press_s_e7", 32'(s), 0);
    step(12);
    bs = 1'b0;
    step(6);
    check_val("rel_busy_f5", 32'(busy), 1);
    step(1);
    check_val("rel_busy_f6", 32'(busy), 0);
    check_val("press_s_count", 32'(s_cnt - s_base), 1);
    check_val("press_r_count", 32'(r_cnt - r_base), 0);
    $display("txn clean_press s_pulses=%0d r_pulses=%0d", s_cnt - s_base, r_cnt - r_base);
    step(3);

    // Glitch of 3 cycles
    mark();
    bs = 1'b1;
    step(3);
    check_val("glitch_busy_mid", 32'(busy), 1);
    bs = 1'b0;
    step(15);
    check_val("glitch_s_count", 32'(s_cnt - s_base), 0);
    check_val("glitch_busy_end", 32'(busy), 0);
    $display("txn glitch s_pulses=%0d busy=%0b", s_cnt - s_base, busy);

    // Bounce for 10 cycles then steady high
    mark();
    for (int i = 0; i < 10; i++) begin
      bs = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(1);
    end
    bs = 1'b1;
    step(6);
    check_val("bounce_s_e5", 32'(s), 0);
    step(1);
    check_val("bounce_s_e6", 32'(s), 1);
    step(10);
    bs = 1'b0;
    step(10);
    check_val("bounce_s_count", 32'(s_cnt - s_base), 1);
    $display("txn bounce s_pulses=%0d", s_cnt - s_base);

    // Simultaneous press on both buttons
    mark();
    bs = 1'b1;
    br = 1'b1;
    step(7);
    check_val("simul_r_e6", 32'(r), 1);
    check_val("simul_s_e6", 32'(s), 0);
    step(20);
    check_val("simul_s_count", 32'(s_cnt - s_base), 0);
    check_val("simul_r_count", 32'(r_cnt - r_base), 1);
    $display("txn simultaneous s_pulses=%0d r_pulses=%0d", s_cnt - s_base, r_cnt - r_base);
    bs = 1'b0;
    br = 1'b0;
    step(10);

    // Reset asserted at debounce count 2, button kept high
    mark();
    bs = 1'b1;
    step(5);
    r_n = 1'b0;
    step(2);
    check_val("rmid_busy_rst", 32'(busy), 0);
    check_val("rmid_s_rst", 32'(s), 0);
    r_n = 1'b1;
    step(6);
    check_val("rmid_s_r5", 32'(s), 0);
    step(1);
    check_val("rmid_s_r6", 32'(s), 1);
    step(5);
    check_val("rmid_s_count", 32'(s_cnt - s_base), 1);
    $display("txn reset_mid s_pulses=%0d", s_cnt - s_base);
    bs = 1'b0;
    step(10);

    // Long hold on reset button, short and sufficient releases
    mark();
    br = 1'b1;
    step(100);
    check_val("hold_r_count", 32'(r_cnt - r_base), 1);
    check_val("hold_s_count", 32'(s_cnt - s_base), 0);
    br = 1'b0;
    step(4);
    br = 1'b1;
    step(20);
    check_val("short_rel_r_count", 32'(r_cnt - r_base), 1);
    br = 1'b0;
    step(5);
    br = 1'b1;
    step(6);
    check_val("repress_r_e5", 32'(r), 0);
    step(1);
    check_val("repress_r_e6", 32'(r), 1);
    step(5);
    check_val("repress_r_count", 32'(r_cnt - r_base), 2);
    $display("txn hold r_pulses=%0d", r_cnt - r_base);
    br = 1'b0;
    step(10);

    check_val("never_both", 32'(both_cnt), 0);
    check_val("final_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
